// File: rtl/register_file.sv
// register_file: integer register file with bypassed read ports and a sequential register dump
//   clk, rst_n                  clock, async active-low reset
//   wr_en, wr_addr, wr_data     writeback write port; x0 and out-of-range indices are dropped
//   rd_addr_a/b -> rd_data_a/b  combinational read ports, same-cycle write bypass
//   dump_req                    rising edge starts a dump of every register, one per cycle
//   dump_valid, dump_idx,       registered dump beat
//   dump_data
//   dump_done                   one-cycle pulse after the last beat
//   busy                        dump sequencer active
module register_file #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = 5,
  parameter logic [BUS_DATA_WIDTH-1:0] SP_INIT = 64'h0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [BUS_DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]         rd_addr_a,
  output logic [BUS_DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_W-1:0]         rd_addr_b,
  output logic [BUS_DATA_WIDTH-1:0] rd_data_b,
  input  logic                      dump_req,
  output logic                      dump_valid,
  output logic [ADDR_W-1:0]         dump_idx,
  output logic [BUS_DATA_WIDTH-1:0] dump_data,
  output logic                      dump_done,
  output logic                      busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DUMP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [BUS_DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [1:0] state;
  logic req_q, start, last, wr_ok;
  assign wr_ok = wr_en && wr_addr != '0 && int'(wr_addr) < NUM_REGS;
  assign start = dump_req & ~req_q;
  assign last = dump_idx == ADDR_W'(NUM_REGS - 1);
  always_comb begin
    rd_data_a = (rd_addr_a == '0 || int'(rd_addr_a) >= NUM_REGS) ? '0 :
                (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
    rd_data_b = (rd_addr_b == '0 || int'(rd_addr_b) >= NUM_REGS) ? '0 :
                (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == 2) ? SP_INIT : '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end
  // dump_data is captured from the array at the edge before its beat, so a write
  // landing during that beat never shows up in it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_q <= 1'b0;
      dump_valid <= 1'b0;
      dump_idx <= '0;
      dump_data <= '0;
      dump_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      req_q <= dump_req;
      case (state)
        IDLE: if (start) begin
          state <= DUMP;
          dump_valid <= 1'b1;
          dump_idx <= '0;
          dump_data <= regs[0];
          busy <= 1'b1;
        end
        DUMP: if (last) begin
          state <= DONE;
          dump_valid <= 1'b0;
          dump_done <= 1'b1;
        end else begin
          dump_idx <= dump_idx + 1'b1;
          dump_data <= regs[dump_idx + 1'b1];
        end
        DONE: begin
          state <= IDLE;
          dump_done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of reset, writes, bypass and the dump sequencer
module tb_register_file;
  localparam int W = 64;
  localparam int N = 32;
  localparam int AW = 5;
  localparam logic [W-1:0] SP = 64'h0000_0000_8000_1000;
  logic clk = 0, rst_n = 0, wr_en = 0, dump_req = 0;
  logic [AW-1:0] wr_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
  logic [W-1:0] wr_data = 0;
  logic [W-1:0] rd_data_a, rd_data_b, dump_data;
  logic dump_valid, dump_done, busy;
  logic [AW-1:0] dump_idx;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  register_file #(.BUS_DATA_WIDTH(W), .NUM_REGS(N), .ADDR_W(AW), .SP_INIT(SP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .dump_req(dump_req), .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_done(dump_done), .busy(busy)
  );
  task automatic test_reset;
    logic [W-1:0] ea, eb;
    rst_n = 0;
    #1;
    checks++;
    if ({dump_valid, dump_done, busy} !== 3'b000 || dump_idx !== '0 || dump_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%b b=%b idx=%0d data=%h exp all 0", dump_valid, dump_done, busy, dump_idx, dump_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < N; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(N - 1 - i);
      ea = (i == 2) ? SP : '0;
      eb = (N - 1 - i == 2) ? SP : '0;
      #1;
      checks++;
      if (rd_data_a !== ea) begin
        failures++;
        $display("FAIL reset_read_a x%0d got=%h exp=%h", i, rd_data_a, ea);
      end
      checks++;
      if (rd_data_b !== eb) begin
        failures++;
        $display("FAIL reset_read_b x%0d got=%h exp=%h", N - 1 - i, rd_data_b, eb);
      end
    end
  endtask
  task automatic test_write;
    @(posedge clk);
    #1 wr_en = 1; wr_addr = 5; wr_data = 64'hDEAD_BEEF_0123_4567;
    @(posedge clk);
    #1 wr_en = 0; rd_addr_a = 5; rd_addr_b = 5;
    #1;
    checks++;
    if (rd_data_a !== 64'hDEAD_BEEF_0123_4567) begin
      failures++;
      $display("FAIL write_x5_a got=%h exp=%h", rd_data_a, 64'hDEAD_BEEF_0123_4567);
    end
    checks++;
    if (rd_data_b !== 64'hDEAD_BEEF_0123_4567) begin
      failures++;
      $display("FAIL write_x5_b got=%h exp=%h", rd_data_b, 64'hDEAD_BEEF_0123_4567);
    end
    wr_en = 1; wr_addr = 0; wr_data = 64'h1; rd_addr_a = 0;
    #1;
    checks++;
    if (rd_data_a !== '0) begin
      failures++;
      $display("FAIL x0_bypass got=%h exp=0", rd_data_a);
    end
    @(posedge clk);
    #1 wr_en = 0;
    #1;
    checks++;
    if (rd_data_a !== '0) begin
      failures++;
      $display("FAIL x0_write got=%h exp=0", rd_data_a);
    end
  endtask
  task automatic test_bypass;
    @(posedge clk);
    #1 wr_en = 1; wr_addr = 7; wr_data = 64'h55; rd_addr_a = 7; rd_addr_b = 7;
    #1;
    checks++;
    if (rd_data_a !== 64'h55 || rd_data_b !== 64'h55) begin
      failures++;
      $display("FAIL bypass_x7 got a=%h b=%h exp=55", rd_data_a, rd_data_b);
    end
    @(posedge clk);
    #1 wr_en = 0;
    #1;
    checks++;
    if (rd_data_a !== 64'h55 || rd_data_b !== 64'h55) begin
      failures++;
      $display("FAIL stored_x7 got a=%h b=%h exp=55", rd_data_a, rd_data_b);
    end
  endtask
  task automatic test_dump;
    int beat, dones, busy_cnt, first;
    for (int i = 1; i < N; i++) begin
      @(posedge clk);
      #1 wr_en = 1; wr_addr = AW'(i); wr_data = W'(i * 3);
    end
    @(posedge clk);
    #1 wr_en = 0; dump_req = 1;
    beat = 0; dones = 0; busy_cnt = 0; first = -1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (dump_done) dones++;
      if (dump_valid) begin
        if (first < 0) first = cyc;
        checks++;
        if (dump_idx !== AW'(beat) || dump_data !== W'(beat * 3)) begin
          failures++;
          $display("FAIL dump_beat%0d got idx=%0d data=%h exp idx=%0d data=%h", beat, dump_idx, dump_data, beat, W'(beat * 3));
        end
        beat++;
      end
    end
    checks++;
    if (beat !== 32) begin failures++; $display("FAIL dump_beats got=%0d exp=32", beat); end
    checks++;
    if (dones !== 1) begin failures++; $display("FAIL dump_done_count got=%0d exp=1", dones); end
    checks++;
    if (busy_cnt !== 33) begin failures++; $display("FAIL busy_cycles got=%0d exp=33", busy_cnt); end
    checks++;
    if (first !== 0) begin failures++; $display("FAIL dump_latency got=%0d exp=0", first); end
    dump_req = 0;
  endtask
  task automatic test_dump_writes;
    int beat, dones;
    logic [W-1:0] exp;
    @(posedge clk);
    #1 dump_req = 1;
    beat = 0; dones = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk);
      #1 wr_en = 0;
      if (dump_done) dones++;
      if (dump_valid) begin
        exp = (beat == 10) ? 64'hAA : W'(beat * 3);
        checks++;
        if (dump_idx !== AW'(beat) || dump_data !== exp) begin
          failures++;
          $display("FAIL dump_wr_beat%0d got idx=%0d data=%h exp idx=%0d data=%h", beat, dump_idx, dump_data, beat, exp);
        end
        beat++;
        if (dump_idx == 4) begin wr_en = 1; wr_addr = 10; wr_data = 64'hAA; end
        if (dump_idx == 12) begin wr_en = 1; wr_addr = 12; wr_data = 64'hBB; end
      end
    end
    checks++;
    if (beat !== 32 || dones !== 1) begin
      failures++;
      $display("FAIL dump_wr_counts got beats=%0d dones=%0d exp 32/1", beat, dones);
    end
    wr_en = 0; dump_req = 0; rd_addr_a = 12; rd_addr_b = 10;
    #1;
    checks++;
    if (rd_data_a !== 64'hBB || rd_data_b !== 64'hAA) begin
      failures++;
      $display("FAIL dump_wr_regs got x12=%h x10=%h exp BB/AA", rd_data_a, rd_data_b);
    end
  endtask
  task automatic test_dump_reset;
    bit found;
    int dones, valids;
    @(posedge clk);
    #1 dump_req = 1;
    found = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (dump_valid && dump_idx == 8) begin found = 1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL dump_reach_idx8 got=0 exp=1"); end
    rst_n = 0; dump_req = 0;
    #1;
    checks++;
    if (dump_valid !== 0 || busy !== 0 || dump_done !== 0 || dump_idx !== '0) begin
      failures++;
      $display("FAIL mid_dump_reset got v=%b b=%b d=%b idx=%0d exp 0", dump_valid, busy, dump_done, dump_idx);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    dones = 0; valids = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (dump_done) dones++;
      if (dump_valid) valids++;
    end
    checks++;
    if (dones !== 0 || valids !== 0) begin
      failures++;
      $display("FAIL post_reset_quiet got dones=%0d valids=%0d exp 0/0", dones, valids);
    end
    rd_addr_a = 2; rd_addr_b = 12;
    #1;
    checks++;
    if (rd_data_a !== SP || rd_data_b !== '0) begin
      failures++;
      $display("FAIL post_reset_regs got x2=%h x12=%h exp %h/0", rd_data_a, rd_data_b, SP);
    end
  endtask
  initial begin
    test_reset;
    test_write;
    test_bypass;
    test_dump;
    test_dump_writes;
    test_dump_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
